// File: rtl/led_drv_pkg.sv
// Shared constants and types for the LED PWM driver.
//   LED_W / LEDR_W / LEDG_W : widths of the packed LED word and its red/green parts
//   LEDR_* / LEDG_*         : bit ranges of the red and green LEDs in the LED word
//   led_state_t             : driver state (LAMP = lamp test, RUN = normal PWM)
package led_drv_pkg;

    localparam int LED_W    = 27;
    localparam int LEDR_W   = 18;
    localparam int LEDG_W   = 9;

    localparam int LEDR_LSB = 0;
    localparam int LEDR_MSB = 17;
    localparam int LEDG_LSB = 18;
    localparam int LEDG_MSB = 26;

    typedef enum logic {
        LAMP = 1'b0,
        RUN  = 1'b1
    } led_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// PWM timebase: a prescaler that divides clk down to PWM ticks, and the PWM
// counter that steps once per tick.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   tick          : high in the cycle the prescaler sits at CLK_DIV-1
//   pwm_cnt       : PWM counter, wraps every 2^PWM_BITS ticks
//   period_start  : tick on the last count of a period (combinational)
module led_tick_gen #(
    parameter int CLK_DIV  = 50,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                tick,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                period_start
);

    // A single-cycle divider still needs a 1-bit register to stay legal.
    localparam int                  PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PRE_W-1:0]    r_presc;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_tick;

    assign w_tick = (r_presc == PRE_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
        end
    end

    assign tick         = w_tick;
    assign pwm_cnt      = r_pwm_cnt;
    assign period_start = w_tick && (r_pwm_cnt == CNT_MAX);

endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM driver: dims a 27-bit LED pattern with a fixed PWM duty. The pattern
// is latched into a shadow register only at period boundaries so a mid-period
// request change never produces a partial period. An optional lamp test lights
// every LED for LAMP_TEST_PERIODS periods after reset.
// Build option: define LED_LAMP_TEST_EN to include the lamp test; without it
// the driver starts directly in normal PWM operation.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   led_req          : requested pattern, [17:0] red, [26:18] green
//   blank            : synchronous force-all-off
//   ledr, ledg       : registered red / green LED drive, active-high
//   period_start     : one-cycle pulse, one cycle after each period boundary
//   lamp_test_active : high while the lamp test runs
//
// state | meaning
// LAMP  | lamp test: all LEDs on, counting period boundaries
// RUN   | normal PWM of the shadowed pattern, held until reset
module led_pwm_driver
    import led_drv_pkg::*;
#(
    parameter int CLK_DIV           = 50,
    parameter int PWM_BITS          = 4,
    parameter int DUTY              = 12,
    parameter int LAMP_TEST_PERIODS = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LED_W-1:0]  led_req,
    input  logic              blank,
    output logic [LEDR_W-1:0] ledr,
    output logic [LEDG_W-1:0] ledg,
    output logic              period_start,
    output logic              lamp_test_active
);

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $fatal(1, "led_pwm_driver: CLK_DIV must be >= 1");
        end
        if (DUTY < 0 || DUTY > (1 << PWM_BITS)) begin : g_bad_duty
            $fatal(1, "led_pwm_driver: DUTY must lie in 0..2^PWM_BITS");
        end
        if (LAMP_TEST_PERIODS < 1) begin : g_bad_lamp
            $fatal(1, "led_pwm_driver: LAMP_TEST_PERIODS must be >= 1");
        end
    endgenerate

    // One extra bit so DUTY = 2^PWM_BITS compares as always-on.
    localparam logic [PWM_BITS:0] DUTY_V = (PWM_BITS + 1)'(DUTY);

    logic                w_tick;
    logic [PWM_BITS-1:0] w_pwm_cnt;
    logic                w_period_start;
    logic                w_pwm_on;
    logic                w_lamp_on;
    logic [LED_W-1:0]    w_led_nxt;

    logic [LED_W-1:0]    r_shadow;
    logic [LED_W-1:0]    r_led;
    logic                r_period_start;

    led_tick_gen #(
        .CLK_DIV  (CLK_DIV),
        .PWM_BITS (PWM_BITS)
    ) u_tick_gen (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (w_tick),
        .pwm_cnt      (w_pwm_cnt),
        .period_start (w_period_start)
    );

    // A period boundary can only ever fall on a PWM tick.
    a_boundary_on_tick : assert property (
        @(posedge clk) disable iff (!reset_n) w_period_start |-> w_tick
    );

    assign w_pwm_on = ({1'b0, w_pwm_cnt} < DUTY_V);

`ifdef LED_LAMP_TEST_EN
    localparam int               LAMP_W    = (LAMP_TEST_PERIODS > 1) ? $clog2(LAMP_TEST_PERIODS) : 1;
    localparam logic [LAMP_W-1:0] LAMP_LAST = LAMP_W'(LAMP_TEST_PERIODS - 1);

    led_state_t        r_state;
    led_state_t        w_state_nxt;
    logic [LAMP_W-1:0] r_lamp_cnt;
    logic [LAMP_W-1:0] w_lamp_cnt_nxt;
    logic              r_lamp_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= LAMP;
            r_lamp_cnt    <= '0;
            r_lamp_active <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_lamp_cnt    <= w_lamp_cnt_nxt;
            r_lamp_active <= (w_state_nxt == LAMP);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lamp_cnt_nxt = r_lamp_cnt;
        case (r_state)
            LAMP: begin
                if (w_period_start) begin
                    if (r_lamp_cnt == LAMP_LAST) begin
                        w_state_nxt    = RUN;
                        w_lamp_cnt_nxt = '0;
                    end else begin
                        w_lamp_cnt_nxt = r_lamp_cnt + 1'b1;
                    end
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_lamp_on        = (r_state == LAMP);
    assign lamp_test_active = r_lamp_active;
`else
    assign w_lamp_on        = 1'b0;
    assign lamp_test_active = 1'b0;
`endif

    // Blank wins over everything but only gates the outputs; the timebase and
    // the shadow capture keep running so the PWM phase never slips.
    always_comb begin
        w_led_nxt = r_shadow & {LED_W{w_pwm_on}};
        if (blank) begin
            w_led_nxt = '0;
        end else if (w_lamp_on) begin
            w_led_nxt = '1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow       <= '0;
            r_led          <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (w_period_start) begin
                r_shadow <= led_req;
            end
            r_led          <= w_led_nxt;
            r_period_start <= w_period_start;
        end
    end

    assign ledr         = r_led[LEDR_MSB:LEDR_LSB];
    assign ledg         = r_led[LEDG_MSB:LEDG_LSB];
    assign period_start = r_period_start;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver with CLK_DIV=2, PWM_BITS=2, LAMP_TEST_PERIODS=3
// (8 clk cycles per period). Three instances share the stimulus: DUTY=2, 0, 4.
// Expected outputs are derived from the edge count since reset release.
module tb_led_pwm_driver;

    localparam int CLK_DIV  = 2;
    localparam int PWM_BITS = 2;
    localparam int LTP      = 3;
    localparam int PERIOD   = CLK_DIV * (1 << PWM_BITS);
    localparam int LAMP_CYC = LTP * PERIOD;

`ifdef LED_LAMP_TEST_EN
    localparam bit LAMP_EN = 1'b1;
`else
    localparam bit LAMP_EN = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [26:0] led_req = '0;
    logic        blank   = 1'b0;

    logic [17:0] ledr_d2, ledr_d0, ledr_d4;
    logic [8:0]  ledg_d2, ledg_d0, ledg_d4;
    logic        ps_d2, ps_d0, ps_d4;
    logic        la_d2, la_d0, la_d4;

    always #5 clk = ~clk;

    led_pwm_driver #(.CLK_DIV(CLK_DIV), .PWM_BITS(PWM_BITS), .DUTY(2), .LAMP_TEST_PERIODS(LTP)) u_dut_d2 (
        .clk(clk), .reset_n(reset_n), .led_req(led_req), .blank(blank),
        .ledr(ledr_d2), .ledg(ledg_d2), .period_start(ps_d2), .lamp_test_active(la_d2));

    led_pwm_driver #(.CLK_DIV(CLK_DIV), .PWM_BITS(PWM_BITS), .DUTY(0), .LAMP_TEST_PERIODS(LTP)) u_dut_d0 (
        .clk(clk), .reset_n(reset_n), .led_req(led_req), .blank(blank),
        .ledr(ledr_d0), .ledg(ledg_d0), .period_start(ps_d0), .lamp_test_active(la_d0));

    led_pwm_driver #(.CLK_DIV(CLK_DIV), .PWM_BITS(PWM_BITS), .DUTY(4), .LAMP_TEST_PERIODS(LTP)) u_dut_d4 (
        .clk(clk), .reset_n(reset_n), .led_req(led_req), .blank(blank),
        .ledr(ledr_d4), .ledg(ledg_d4), .period_start(ps_d4), .lamp_test_active(la_d4));

    typedef struct {
        int          k;
        logic [26:0] led_d2;
        logic [26:0] led_d0;
        logic [26:0] led_d4;
        logic        ps;
        logic        la;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          k        = 0;
    logic [26:0] m_shadow = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output after edge kk reflects the inputs and PWM phase just before it.
    function automatic logic [26:0] exp_led(input int kk, input logic blk,
                                            input logic [26:0] shd, input int duty);
        if (blk) return '0;
        if (LAMP_EN && kk <= LAMP_CYC) return '1;
        if ((((kk - 1) / CLK_DIV) % (1 << PWM_BITS)) < duty) return shd;
        return '0;
    endfunction

    // Entered at a negedge: drive inputs for the next edge, record what it
    // must produce, then return at the following negedge.
    task automatic cyc(input logic [26:0] req, input logic blk);
        exp_t e;
        led_req = req;
        blank   = blk;
        k++;
        e.k      = k;
        e.led_d2 = exp_led(k, blk, m_shadow, 2);
        e.led_d0 = exp_led(k, blk, m_shadow, 0);
        e.led_d4 = exp_led(k, blk, m_shadow, 4);
        e.ps     = (k % PERIOD == 0);
        e.la     = LAMP_EN && (k < LAMP_CYC);
        sb_q.push_back(e);
        if (k % PERIOD == 0) m_shadow = req;
        @(negedge clk);
    endtask

    task automatic chk_in_reset(input string tag);
        chk({tag, " led_d2"}, {5'b0, ledg_d2, ledr_d2}, 32'h0);
        chk({tag, " led_d4"}, {5'b0, ledg_d4, ledr_d4}, 32'h0);
        chk({tag, " period_start"}, {31'b0, ps_d2}, 32'h0);
        chk({tag, " lamp_active"}, {31'b0, la_d2}, {31'b0, LAMP_EN});
    endtask

    // Entered at a negedge: reset asserted mid-cycle, must clear asynchronously.
    task automatic pulse_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 chk_in_reset(tag);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        k        = 0;
        m_shadow = '0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk($sformatf("led_d2 k=%0d", mon_e.k), {5'b0, ledg_d2, ledr_d2}, {5'b0, mon_e.led_d2});
                chk($sformatf("led_d0 k=%0d", mon_e.k), {5'b0, ledg_d0, ledr_d0}, {5'b0, mon_e.led_d0});
                chk($sformatf("led_d4 k=%0d", mon_e.k), {5'b0, ledg_d4, ledr_d4}, {5'b0, mon_e.led_d4});
                chk($sformatf("period_start k=%0d", mon_e.k), {31'b0, ps_d2}, {31'b0, mon_e.ps});
                chk($sformatf("period_start_d4 k=%0d", mon_e.k), {31'b0, ps_d4}, {31'b0, mon_e.ps});
                chk($sformatf("lamp_active k=%0d", mon_e.k), {31'b0, la_d2}, {31'b0, mon_e.la});
                chk($sformatf("lamp_active_d0 k=%0d", mon_e.k), {31'b0, la_d0}, {31'b0, mon_e.la});
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_in_reset("reset");
        reset_n = 1'b1;
        k       = 0;

        // Lamp test (or early RUN) with blank inside it, then a single red LED.
        for (int i = 1; i <= 32; i++)
            cyc((i >= 25) ? 27'h0000001 : 27'h0, (i >= 10 && i <= 12));
        // Mid-period request change: old pattern holds until the next boundary.
        for (int i = 33; i <= 80; i++)
            cyc((i >= 60) ? 27'h4000000 : 27'h0000001, 1'b0);
        // Blank in RUN; phase must not slip.
        for (int i = 81; i <= 96; i++)
            cyc(27'h4000000, (i >= 83 && i <= 85));
        // All-ones request exercises the DUTY=0 and DUTY=4 instances.
        for (int i = 97; i <= 120; i++)
            cyc(27'h7FFFFFF, 1'b0);

        pulse_reset("reset in run");
        for (int i = 1; i <= 12; i++)
            cyc(27'h7FFFFFF, 1'b0);
        pulse_reset("reset mid lamp");
        for (int i = 1; i <= 40; i++)
            cyc((i < 20) ? 27'h2AAAAAA : 27'h1555555, (i == 30));

        #3;
        chk("scoreboard drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
